// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: credit-throttled sequencer for a 16-bit Fibonacci generator with output FIFO
// Ports:
//   clock_1_i      single clock, rising edge
//   reset_i        asynchronous active-high reset
//   start_i        1-cycle command, sampled only in IDLE
//   count_i        number of terms, latched on an accepted start
//   abort_i        return to IDLE, flush FIFO, no done
//   busy_o         high whenever not IDLE
//   done_o         1-cycle completion pulse
//   err_o          sticky overflow flag (tied 0 unless FIB_SEQ_OVF_EN)
//   fib_clr_o      registered generator clear
//   f_en_o         generator enable, one term per high cycle
//   f_valid_i      generator term valid, one cycle after f_en_o
//   f_in_i         generator term
//   data_out_o     FIFO head (0 when empty)
//   data_valid_o   FIFO not empty
//   data_ready_i   consumer accept
// Optional feature: define FIB_SEQ_OVF_EN to stop the sequence at the first wrapped term.
module fib_seq_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock_1_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             fib_clr_o,
    output logic             f_en_o,
    input  logic             f_valid_i,
    input  logic [15:0]      f_in_i,
    output logic [15:0]      data_out_o,
    output logic             data_valid_o,
    input  logic             data_ready_i
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;
    state_t           state_q;
    logic [CNT_W-1:0] count_l_q, issued_q;
    logic             inflight_q, done_q, fib_clr_q;
    logic [15:0]      mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      occ_q;
    logic             go, accept, drop, ovf, push, pop, f_en;

    assign go     = state_q == IDLE && start_i && count_i != '0;
    assign accept = f_valid_i && (state_q == RUN || state_q == DRAIN);
    assign push   = accept && !drop;
    assign pop    = data_valid_o && data_ready_i;
    // Credits: every issued term must already own a FIFO slot when it arrives.
    assign f_en   = state_q == RUN && !err_o && issued_q < count_l_q &&
                    (AW+2)'(occ_q) + (AW+2)'(inflight_q) < (AW+2)'(DEPTH);

`ifdef FIB_SEQ_OVF_EN
    logic        err_q;
    logic [15:0] last_q;
    logic [1:0]  ncap_q;
    // A Fibonacci term smaller than its predecessor can only come from a 16-bit wrap.
    assign ovf   = accept && !err_q && ncap_q == 2'd2 && f_in_i < last_q;
    assign drop  = err_q || ovf;
    assign err_o = err_q;
    always_ff @(posedge clock_1_i or posedge reset_i) begin
        if (reset_i) begin
            err_q  <= 1'b0;
            last_q <= '0;
            ncap_q <= '0;
        end else if (go) begin
            err_q  <= 1'b0;
            ncap_q <= '0;
        end else if (!(abort_i && busy_o)) begin
            if (ovf) err_q <= 1'b1;
            if (push) last_q <= f_in_i;
            if (push && ncap_q != 2'd2) ncap_q <= ncap_q + 2'd1;
        end
    end
`else
    assign ovf   = 1'b0;
    assign drop  = 1'b0;
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clock_1_i) begin
        if (push) mem_q[wptr_q] <= f_in_i;
    end

    always_ff @(posedge clock_1_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            count_l_q  <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            fib_clr_q  <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
        end else begin
            done_q     <= 1'b0;
            fib_clr_q  <= 1'b0;
            inflight_q <= f_en;
            wptr_q     <= wptr_q + AW'(push);
            rptr_q     <= rptr_q + AW'(pop);
            occ_q      <= occ_q + (AW+1)'(push) - (AW+1)'(pop);
            if (abort_i && busy_o) begin
                state_q    <= IDLE;
                inflight_q <= 1'b0;
                wptr_q     <= '0;
                rptr_q     <= '0;
                occ_q      <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (go) begin
                            state_q   <= CLEAR;
                            count_l_q <= count_i;
                            issued_q  <= '0;
                            fib_clr_q <= 1'b1;
                        end else if (start_i) begin
                            done_q <= 1'b1;
                        end
                    end
                    CLEAR: state_q <= RUN;
                    RUN: begin
                        if (f_en) issued_q <= issued_q + 1'b1;
                        if (ovf || issued_q == count_l_q) state_q <= DRAIN;
                    end
                    DRAIN: begin
                        if (occ_q == '0 && !inflight_q) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy_o       = state_q != IDLE;
    assign done_o       = done_q;
    assign fib_clr_o    = fib_clr_q;
    assign f_en_o       = f_en;
    assign data_valid_o = occ_q != '0;
    assign data_out_o   = data_valid_o ? mem_q[rptr_q] : 16'h0;
endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb_fib_seq_ctrl: randomized self-checking bench with a generator stub and a sequence model
module tb_fib_seq_ctrl;
    localparam int DEPTH = 4;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, data_ready = 1'b0;
    logic [7:0]  count = '0;
    logic        busy, done, err, fib_clr, f_en, f_valid, data_valid;
    logic [15:0] f_in, data_out, gen_a, gen_b;
    int          checks = 0, errors = 0;
    int          cyc = 0, done_cnt = 0, fen_cnt = 0, clr_cnt = 0, busy_cnt = 0, bad_busy = 0;
    logic [15:0] got[$], exp_q[$];
    int          got_cyc[$];
    bit          exp_err;

    fib_seq_ctrl #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clock_1_i(clk), .reset_i(reset), .start_i(start), .count_i(count), .abort_i(abort),
        .busy_o(busy), .done_o(done), .err_o(err), .fib_clr_o(fib_clr), .f_en_o(f_en),
        .f_valid_i(f_valid), .f_in_i(f_in), .data_out_o(data_out), .data_valid_o(data_valid),
        .data_ready_i(data_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset || fib_clr) begin
            gen_a <= 16'd0; gen_b <= 16'd1; f_valid <= 1'b0; f_in <= 16'd0;
        end else begin
            f_valid <= f_en;
            if (f_en) begin f_in <= gen_a; gen_a <= gen_b; gen_b <= gen_a + gen_b; end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            cyc++;
            if (data_valid && data_ready) begin got.push_back(data_out); got_cyc.push_back(cyc); end
            if (done) done_cnt++;
            if (f_en) fen_cnt++;
            if (fib_clr) clr_cnt++;
            if (busy) busy_cnt++;
            if (done && busy) bad_busy++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        got.delete(); got_cyc.delete();
        done_cnt = 0; fen_cnt = 0; clr_cnt = 0; busy_cnt = 0; bad_busy = 0;
    endtask

    task automatic build_exp(input int n);
        int a = 0, b = 1, prev = 0, t;
        exp_q.delete(); exp_err = 0;
        for (int i = 0; i < n; i++) begin
`ifdef FIB_SEQ_OVF_EN
            if (i >= 2 && a < prev) begin exp_err = 1; break; end
`endif
            exp_q.push_back(16'(a));
            prev = a; t = (a + b) % 65536; a = b; b = t;
        end
    endtask

    task automatic run_seq(input int n, input int rmode, input int poke, input string nm);
        clear_mon();
        build_exp(n);
        count = 8'(n); start = 1'b1; tick(); start = 1'b0; count = 8'($urandom);
        for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
            data_ready = rmode == 0 ? 1'b1 : ($urandom % 3 != 0);
            start = c == poke;
            if (c == poke) count = 8'd2;
            tick();
        end
        start = 1'b0; data_ready = 1'b1;
        checks++;
        if (done_cnt == 0) begin errors++; $display("FAIL %s timeout: done_cnt %0d expected 1", nm, done_cnt); end
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL %s length: got %0d expected %0d", nm, got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL %s term %0d: got %0d expected %0d", nm, i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL %s err: got %0b expected %0b", nm, err, exp_err); end
        tick(); tick();
        checks++;
        if (done_cnt != 1 || busy !== 1'b0 || bad_busy != 0) begin
            errors++; $display("FAIL %s end: done_cnt %0d busy %0b bad_busy %0d expected 1 0 0", nm, done_cnt, busy, bad_busy);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, err, f_en, data_valid, fib_clr} !== 6'b0 || data_out !== 16'h0) begin
            errors++; $display("FAIL reset: outs %b data_out %0d expected 000000 0", {busy, done, err, f_en, data_valid, fib_clr}, data_out);
        end
    endtask

    task automatic test_basic();
        run_seq(5, 0, -1, "t1");
        for (int i = 1; i < got_cyc.size(); i++) begin
            checks++;
            if (got_cyc[i] - got_cyc[0] != i) begin
                errors++; $display("FAIL t1 spacing %0d: got %0d expected %0d", i, got_cyc[i] - got_cyc[0], i);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_mon();
        build_exp(10);
        data_ready = 1'b0; count = 8'd10; start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        checks++;
        if (fen_cnt != DEPTH || data_valid !== 1'b1 || data_out !== 16'd0) begin
            errors++; $display("FAIL t2 credit: f_en %0d valid %0b head %0d expected %0d 1 0", fen_cnt, data_valid, data_out, DEPTH);
        end
        data_ready = 1'b1;
        for (int c = 0; c < 200 && done_cnt == 0; c++) tick();
        checks++;
        if (got.size() != 10) begin errors++; $display("FAIL t2 length: got %0d expected 10", got.size()); end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t2 term %0d: got %0d expected %0d", i, got[i], exp_q[i]); end
        end
        checks++;
        if (got.size() != 10 || got[9] !== 16'd34 || done_cnt != 1) begin
            errors++; $display("FAIL t2 last: size %0d done_cnt %0d expected 10 terms ending 34 and one done", got.size(), done_cnt);
        end
    endtask

    task automatic test_zero();
        clear_mon();
        count = 8'd0; start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t3 done: got %0b busy %0b expected 1 0", done, busy); end
        tick(); tick();
        checks++;
        if (done !== 1'b0 || fen_cnt != 0 || clr_cnt != 0 || busy_cnt != 0 || done_cnt != 1) begin
            errors++; $display("FAIL t3 quiet: done %0b f_en %0d clr %0d busy %0d dones %0d expected 0 0 0 0 1", done, fen_cnt, clr_cnt, busy_cnt, done_cnt);
        end
    endtask

    task automatic test_abort();
        clear_mon();
        data_ready = 1'b1; count = 8'd8; start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 200 && got.size() < 3; c++) tick();
        data_ready = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            errors++; $display("FAIL t4 abort: busy %0b valid %0b expected 0 0", busy, data_valid);
        end
        data_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        checks++;
        if (done_cnt != 0 || got.size() != 3) begin
            errors++; $display("FAIL t4 quiet: dones %0d terms %0d expected 0 3", done_cnt, got.size());
        end
        run_seq(3, 0, -1, "t4_restart");
    endtask

    task automatic test_overflow();
        run_seq(30, 0, -1, "t5");
        checks++;
`ifdef FIB_SEQ_OVF_EN
        if (got.size() != 25 || got[got.size()-1] !== 16'd46368 || err !== 1'b1) begin
            errors++; $display("FAIL t5 ovf: terms %0d err %0b expected 25 ending 46368 err 1", got.size(), err);
        end
`else
        if (got.size() != 30 || got[25] !== 16'd9489 || err !== 1'b0) begin
            errors++; $display("FAIL t5 wrap: terms %0d err %0b expected 30 with index 25 = 9489 err 0", got.size(), err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        clear_mon();
        data_ready = 1'b0; count = 8'd20; start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        reset = 1'b1; #1;
        checks++;
        if ({busy, done, err, f_en, data_valid, fib_clr} !== 6'b0 || data_out !== 16'h0) begin
            errors++; $display("FAIL t6 reset: outs %b data_out %0d expected 000000 0", {busy, done, err, f_en, data_valid, fib_clr}, data_out);
        end
        tick(); reset = 1'b0; tick();
        run_seq(6, 0, 4, "t6_busy_start");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) run_seq($urandom_range(1, 40), 1, -1, "rand");
    endtask

    initial begin
        tick(); tick();
        test_reset();
        reset = 1'b0; tick();
        test_basic();
        test_backpressure();
        test_zero();
        test_abort();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
